// File: rtl/sad_pkg.sv
// Shared definitions for the SAD matcher: result encoding, ASCII bytes,
// sequencer state enum and the result-message byte selector.
package sad_pkg;

  localparam logic [1:0] RES_OFF       = 2'd0;
  localparam logic [1:0] RES_MATCH     = 2'd1;
  localparam logic [1:0] RES_NOT_MATCH = 2'd2;

  localparam logic [7:0] ASCII_M = 8'h4D;
  localparam logic [7:0] ASCII_N = 8'h4E;
  localparam logic [7:0] ASCII_0 = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CONV_H, ST_CONV_T, ST_SEND, ST_DONE, ST_RELEASE
  } seq_state_e;

  // MATCH: 'M' h t o TERM; NOT_MATCH: 'N' TERM
  function automatic logic [7:0] msg_byte(input logic [1:0] code, input logic [2:0] idx,
                                          input logic [3:0] hund, input logic [3:0] tens,
                                          input logic [3:0] ones, input logic [7:0] term);
    logic [7:0] b;
    b = term;
    if (code == RES_MATCH) begin
      case (idx)
        3'd0:    b = ASCII_M;
        3'd1:    b = ASCII_0 + {4'd0, hund};
        3'd2:    b = ASCII_0 + {4'd0, tens};
        3'd3:    b = ASCII_0 + {4'd0, ones};
        default: b = term;
      endcase
    end else if (idx == 3'd0) begin
      b = ASCII_N;
    end
    return b;
  endfunction

endpackage

// File: rtl/bin_to_dec3.sv
// Sequential binary-to-3-digit decimal converter using repeated subtraction:
// one cycle per hundred, one per ten, plus one phase-exit cycle each.
module bin_to_dec3 #(
  parameter int ROW_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [ROW_W-1:0] value,
  output logic             hund_done,
  output logic             done,
  output logic [3:0]       hund,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  typedef enum logic [1:0] {PH_IDLE, PH_HUND, PH_TENS} conv_phase_e;

  localparam logic [ROW_W-1:0] C100 = ROW_W'(100);
  localparam logic [ROW_W-1:0] C10  = ROW_W'(10);

  conv_phase_e      phase_q, phase_d;
  logic [ROW_W-1:0] rem_q, rem_d;
  logic [3:0]       hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;

  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (phase_q)
      PH_IDLE: if (start) begin
        rem_d   = value;
        hund_d  = 4'd0;
        tens_d  = 4'd0;
        ones_d  = 4'd0;
        phase_d = PH_HUND;
      end
      PH_HUND: if (rem_q >= C100) begin
        rem_d  = rem_q - C100;
        hund_d = hund_q + 4'd1;
      end else begin
        phase_d = PH_TENS;
      end
      PH_TENS: if (rem_q >= C10) begin
        rem_d  = rem_q - C10;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d  = rem_q[3:0];
        phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      rem_q   <= '0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign hund_done = (phase_q == PH_HUND) && (rem_q < C100);
  assign done      = (phase_q == PH_TENS) && (rem_q < C10);
  assign hund      = hund_q;
  assign tens      = tens_q;
  assign ones      = ones_q;

endmodule

// File: rtl/uart_result_sequencer.sv
// Formats the SAD match result as an ASCII message and streams it to the
// UART byte transmitter, then pulses send_complete back to the control unit.
module uart_result_sequencer
  import sad_pkg::*;
#(
  parameter int         ROW_W     = 9,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       result_code,
  input  logic [ROW_W-1:0] match_row,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             send_complete,
  output logic             busy
);

  seq_state_e state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [2:0] idx_q, idx_d, idx_nxt, last_idx;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       send_complete_q, send_complete_d;
  logic       busy_q, busy_d;

  logic       conv_start, conv_hund_done, conv_done;
  logic [3:0] hund, tens, ones;

  assign conv_start = (state_q == ST_IDLE) && (result_code == RES_MATCH);

  bin_to_dec3 #(.ROW_W(ROW_W)) u_conv (
    .clock     (clock),
    .reset     (reset),
    .start     (conv_start),
    .value     (match_row),
    .hund_done (conv_hund_done),
    .done      (conv_done),
    .hund      (hund),
    .tens      (tens),
    .ones      (ones)
  );

  assign last_idx = (code_q == RES_MATCH) ? 3'd4 : 3'd1;
  assign idx_nxt  = idx_q + 3'd1;

  always_comb begin
    state_d         = state_q;
    code_d          = code_q;
    idx_d           = idx_q;
    tx_data_d       = tx_data_q;
    tx_valid_d      = tx_valid_q;
    send_complete_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (result_code == RES_MATCH) begin
          code_d  = RES_MATCH;
          state_d = ST_CONV_H;
        end else if (result_code == RES_NOT_MATCH) begin
          // No digits to compute: first byte is ready immediately
          code_d     = RES_NOT_MATCH;
          state_d    = ST_SEND;
          idx_d      = 3'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = ASCII_N;
        end
      end
      ST_CONV_H: if (conv_hund_done) state_d = ST_CONV_T;
      ST_CONV_T: if (conv_done) begin
        state_d    = ST_SEND;
        idx_d      = 3'd0;
        tx_valid_d = 1'b1;
        tx_data_d  = ASCII_M;
      end
      ST_SEND: if (tx_valid_q && tx_ready) begin
        if (idx_q == last_idx) begin
          state_d         = ST_DONE;
          tx_valid_d      = 1'b0;
          send_complete_d = 1'b1;
        end else begin
          idx_d     = idx_nxt;
          tx_data_d = msg_byte(code_q, idx_nxt, hund, tens, ones, TERM_CHAR);
        end
      end
      ST_DONE: state_d = ST_RELEASE;
      // Control unit holds its code one cycle past the pulse; wait it out
      ST_RELEASE: if (result_code != RES_MATCH && result_code != RES_NOT_MATCH)
        state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      code_q          <= RES_OFF;
      idx_q           <= 3'd0;
      tx_data_q       <= 8'h00;
      tx_valid_q      <= 1'b0;
      send_complete_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      code_q          <= code_d;
      idx_q           <= idx_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      send_complete_q <= send_complete_d;
      busy_q          <= busy_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign send_complete = send_complete_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_result_sequencer.sv
// Directed bench for uart_result_sequencer: message bytes, conversion latency,
// stall stability, release behaviour, mid-message reset and reserved code.
module tb_uart_result_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] result_code = 2'd0;
  logic [8:0] match_row = 9'd0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       send_complete;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_result_sequencer #(.ROW_W(9), .TERM_CHAR(8'h0A)) dut (
    .clock         (clock),
    .reset         (reset),
    .result_code   (result_code),
    .match_row     (match_row),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .send_complete (send_complete),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer monitor: records bytes, counts pulses, checks hold-while-stalled
  logic [7:0] rxq[$];
  int         sc_cnt = 0;
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       last_term = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      stall_q   <= 1'b0;
      last_term <= 1'b0;
    end else begin
      if (stall_q) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_data});
      if (send_complete) begin
        sc_cnt <= sc_cnt + 1;
        check("sc_after_term", {31'd0, last_term}, 32'd1);
      end
      last_term <= tx_valid && tx_ready && (tx_data == 8'h0A);
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
      stall_q    <= tx_valid && !tx_ready;
      stall_data <= tx_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one result, measure latch-to-valid latency, collect the message
  task automatic run_msg(input string name, input logic [1:0] code, input logic [8:0] row,
                         input bit rnd, input int exp_lat, input logic [39:0] exp, input int n);
    int base, sc_base, lat, seen;
    base    = rxq.size();
    sc_base = sc_cnt;
    tx_ready = 1'b1;
    result_code = code;
    match_row   = row;
    tick();
    result_code = 2'd0;
    match_row   = 9'd0;
    lat = 0;
    while (!tx_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat);
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (sc_cnt > sc_base) begin
        seen = 1;
        break;
      end
    end
    tx_ready = 1'b1;
    check({name, "_done_seen"}, seen, 1);
    tick();
    tick();
    check({name, "_len"}, rxq.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < rxq.size())
        check($sformatf("%s_byte%0d", name, i), {24'd0, rxq[base + i]}, {24'd0, exp[39 - 8*i -: 8]});
    check({name, "_sc_once"}, sc_cnt - sc_base, 1);
    check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base, sc_base, w;
    repeat (3) tick();
    check("rst_valid", {31'd0, tx_valid}, 0);
    check("rst_data", {24'd0, tx_data}, 0);
    check("rst_sc", {31'd0, send_complete}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    tick();

    run_msg("m379", 2'd1, 9'd379, 1'b0, 12, 40'h4D3337390A, 5);
    run_msg("nm",   2'd2, 9'd100, 1'b0, 0,  40'h4E0A000000, 2);
    run_msg("m0",   2'd1, 9'd0,   1'b0, 2,  40'h4D3030300A, 5);
    run_msg("m511", 2'd1, 9'd511, 1'b0, 8,  40'h4D3531310A, 5);
    run_msg("m42r", 2'd1, 9'd42,  1'b1, 6,  40'h4D3034320A, 5);

    // Code held after the pulse must not start a second message
    base = rxq.size();
    sc_base = sc_cnt;
    result_code = 2'd1;
    match_row = 9'd5;
    w = 0;
    while (sc_cnt == sc_base && w < 100) begin
      tick();
      w++;
    end
    check("hold_sc_seen", sc_cnt - sc_base, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_busy", {31'd0, busy}, 1);
    end
    result_code = 2'd0;
    tick();
    check("hold_busy_fall", {31'd0, busy}, 0);
    repeat (20) tick();
    check("hold_len", rxq.size() - base, 5);
    check("hold_sc_once", sc_cnt - sc_base, 1);
    if (rxq.size() >= base + 5) begin
      check("hold_b1", {24'd0, rxq[base + 1]}, 32'h30);
      check("hold_b3", {24'd0, rxq[base + 3]}, 32'h35);
    end

    // Reset after the second byte of a MATCH aborts without a pulse
    base = rxq.size();
    sc_base = sc_cnt;
    result_code = 2'd1;
    match_row = 9'd123;
    tick();
    result_code = 2'd0;
    w = 0;
    while (rxq.size() < base + 2 && w < 100) begin
      tick();
      w++;
    end
    check("rst_mid_two_bytes", rxq.size() - base, 2);
    reset = 1'b1;
    tick();
    check("rst_mid_valid", {31'd0, tx_valid}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    repeat (10) tick();
    check("rst_mid_no_sc", sc_cnt - sc_base, 0);
    check("rst_mid_no_more", rxq.size() - base, 2);

    // Reserved code is treated as OFF
    base = rxq.size();
    result_code = 2'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("res3_busy", {31'd0, busy}, 0);
    end
    check("res3_valid", {31'd0, tx_valid}, 0);
    check("res3_no_bytes", rxq.size() - base, 0);
    result_code = 2'd0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_result_sequencer.md
Name: uart_result_sequencer

Overview:
Formats and sequences the UART result message for the SAD matcher once the control unit reaches its finish state. It latches the 2-bit result code and the matching image row, converts the row to three ASCII decimal digits, and streams bytes to the byte-level UART transmitter over a valid/ready handshake. When the message is done it returns the one-cycle send-complete pulse that lets the control unit go back to idle.

Parameters:
ROW_W, 9, width of the match row index; values 0..511.
TERM_CHAR, 8'h0A, message terminator byte.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
result_code  in  2  0=OFF, 1=MATCH, 2=NOT_MATCH, 3=reserved (treated as OFF)
match_row  in  ROW_W  image row of the match; sampled with result_code
tx_data  out  8  byte to the UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts tx_data at this edge
send_complete  out  1  one-cycle pulse after the final byte is transferred
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; tx_valid=0, tx_data=0, send_complete=0, busy=0. Reset applied mid-message aborts it, with no complete pulse. tx_valid is low in the cycle after the reset edge.
- Transfer rule: a byte transfers on an edge where tx_valid and tx_ready are both 1. tx_valid never depends combinationally on tx_ready. Once tx_valid is raised, tx_valid and tx_data hold until the transfer.
- States: IDLE, CONV_H, CONV_T, SEND, DONE, RELEASE.
- IDLE: when result_code is 1 or 2, latch the code and match_row, then go to CONV_H for MATCH or SEND for NOT_MATCH. Code 0 or 3 keeps the block in IDLE.
- CONV_H: each cycle, if rem>=100 then rem-=100 and hund++; otherwise go to CONV_T.
- CONV_T: each cycle, if rem>=10 then rem-=10 and tens++; otherwise ones=rem and go to SEND.
- Conversion takes h+t+2 cycles, where h and t are the hundreds and tens digits.
- Digit registers are 4 bits wide. The ASCII digit is 8'h30+digit.
- SEND, MATCH message: 5 bytes in order: 8'h4D ('M'), hundreds, tens, ones, TERM_CHAR.
- SEND, NOT_MATCH message: 2 bytes: 8'h4E ('N'), TERM_CHAR.
- SEND byte index: a 3-bit counter that advances only on a transfer. The transfer of the last byte moves the block to DONE, with tx_valid low in DONE.
- DONE: send_complete=1 for exactly one cycle, then go to RELEASE.
- RELEASE: wait until result_code reads OFF (0 or 3), then go to IDLE. The control unit's result code is registered and stays asserted one cycle after the pulse. RELEASE prevents that cycle from starting a duplicate message.
- Input changes after the latch are ignored until the block is back in IDLE.
- busy=1 in all states except IDLE.
- Widths: rem is ROW_W bits and the subtractions are unsigned. Every 9-bit value is at most 511, so the hundreds digit is at most 5 and no digit overflows.

Decomposition:
- Shared package sad_pkg holds:
  - result code constants RES_OFF, RES_MATCH, RES_NOT_MATCH, matching the control unit's encoding;
  - ASCII constants ASCII_M, ASCII_N, ASCII_0;
  - the state enum for this block.
- One natural sub-module, bin_to_dec3: a sequential repeated-subtraction converter with start/done handshake and hund/tens/ones outputs. It implements CONV_H and CONV_T. The top level keeps the sequencing FSM and the byte mux.

Test Plan:
- result_code=1, match_row=379, tx_ready=1 -> bytes 4D 33 37 39 0A in order; send_complete high exactly once, on the cycle after the 0A transfer.
- result_code=2 -> bytes 4E 0A, then one send_complete pulse; no conversion cycles (tx_valid rises the cycle after the latch).
- match_row=0 and then 511 -> digit bytes 30 30 30 and 35 31 31.
- MATCH, row 42, tx_ready toggled pseudo-randomly -> tx_data/tx_valid stable whenever stalled; stream still 4D 30 34 32 0A.
- result_code held at 1 for 3 cycles after send_complete, then 0 -> exactly one message; busy falls after result_code reaches 0.
- Reset asserted after the 2nd byte of a MATCH -> tx_valid=0 and busy=0 next cycle; no send_complete. result_code=3 -> block stays in IDLE with no bytes.
